// File: rtl/led_arb_pkg.sv
// Shared definitions for the LED pin arbiters: FSM states, LED count and
// the round-robin winner search.
package led_arb_pkg;

    localparam int LED_NUM = 3;
    localparam int MAX_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        SWITCH = 2'd2
    } arb_state_e;

    // First set request searching upward from ptr+1, wrapping at n.
    // Returns ptr unchanged when no request is set.
    function automatic logic [IDX_W-1:0] rr_next(
        input logic [MAX_REQ-1:0] req,
        input logic [IDX_W-1:0]   ptr,
        input int                 n
    );
        logic [IDX_W-1:0] win;
        logic             found;
        int               k;
        win   = ptr;
        found = 1'b0;
        for (int i = 1; i <= MAX_REQ; i++) begin
            k = int'(ptr) + i;
            if (k >= n) k = k - n;
            if (i <= n && !found && req[k[IDX_W-1:0]]) begin
                win   = k[IDX_W-1:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/led_pwm.sv
// Free-running PWM counter and brightness compare for the three LEDs.
// Only instantiated when LED_ARB_PWM_EN is defined.
module led_pwm
    import led_arb_pkg::*;
#(
    parameter int PWM_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LED_NUM-1:0] pattern_i,
    input  logic [PWM_W-1:0]   duty_i,
    output logic [LED_NUM-1:0] led_o
);

    logic [PWM_W-1:0] pwm_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pwm_cnt <= '0;
        else     pwm_cnt <= pwm_cnt + 1'b1;
    end

    // duty 0 never lights; full-scale duty is dark for one phase only
    assign led_o = (pwm_cnt < duty_i) ? pattern_i : '0;

endmodule

// File: rtl/led_arbiter.sv
// Round-robin time-sliced arbiter for the three user LED pins.
// Define LED_ARB_PWM_EN to enable per-requester PWM brightness via duty_i.
module led_arbiter
    import led_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TICK_DIV    = 20800,
    parameter int SLICE_TICKS = 50,
    parameter int PWM_W       = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [3*NUM_REQ-1:0]     pattern_i,
    input  logic [PWM_W*NUM_REQ-1:0] duty_i,
    output logic [NUM_REQ-1:0]       grant_o,
    output logic [LED_NUM-1:0]       led_o,
    output logic                     busy_o
);

    localparam int PRE_W = $clog2(TICK_DIV);
    localparam int SL_W  = (SLICE_TICKS > 1) ? $clog2(SLICE_TICKS) : 1;

    arb_state_e         state;
    logic [IDX_W-1:0]   rr_ptr;
    logic [PRE_W-1:0]   presc;
    logic [SL_W-1:0]    slice;

    logic [MAX_REQ-1:0] req_ext;
    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   sel_idx;
    logic               any_req;
    logic               cur_req;
    logic               tick;
    logic               slice_end;
    logic [LED_NUM-1:0] pat_sel;
    logic [LED_NUM-1:0] led_next;

    assign req_ext   = MAX_REQ'(req_i);
    assign any_req   = |req_i;
    assign winner    = rr_next(req_ext, rr_ptr, NUM_REQ);
    // rr_ptr doubles as the index of the current grant while ACTIVE
    assign cur_req   = req_ext[rr_ptr];
    assign tick      = (presc == PRE_W'(TICK_DIV - 1));
    assign slice_end = tick && (slice == SL_W'(SLICE_TICKS - 1));
    assign sel_idx   = (state == ACTIVE) ? rr_ptr : winner;

    always_comb begin
        pat_sel = '0;
        for (int k = 0; k < NUM_REQ; k++)
            if (sel_idx == IDX_W'(k)) pat_sel = pattern_i[3*k +: 3];
    end

`ifdef LED_ARB_PWM_EN
    logic [PWM_W-1:0] duty_sel;

    always_comb begin
        duty_sel = '0;
        for (int k = 0; k < NUM_REQ; k++)
            if (sel_idx == IDX_W'(k)) duty_sel = duty_i[PWM_W*k +: PWM_W];
    end

    led_pwm #(.PWM_W(PWM_W)) u_pwm (
        .clk       (clk),
        .rst       (rst),
        .pattern_i (pat_sel),
        .duty_i    (duty_sel),
        .led_o     (led_next)
    );
`else
    logic unused_duty;
    assign unused_duty = ^duty_i;
    assign led_next    = pat_sel;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rr_ptr  <= IDX_W'(NUM_REQ - 1);
            presc   <= '0;
            slice   <= '0;
            grant_o <= '0;
            led_o   <= '0;
            busy_o  <= 1'b0;
        end else begin
            case (state)
                IDLE, SWITCH: begin
                    if (any_req) begin
                        state   <= ACTIVE;
                        rr_ptr  <= winner;
                        presc   <= '0;
                        slice   <= '0;
                        grant_o <= NUM_REQ'(1) << winner;
                        led_o   <= led_next;
                        busy_o  <= 1'b1;
                    end else begin
                        state   <= IDLE;
                        grant_o <= '0;
                        led_o   <= '0;
                        busy_o  <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (!cur_req || slice_end) begin
                        state   <= SWITCH;
                        grant_o <= '0;
                        led_o   <= '0;
                        busy_o  <= 1'b0;
                    end else begin
                        led_o <= led_next;
                        if (tick) begin
                            presc <= '0;
                            slice <= slice + 1'b1;
                        end else begin
                            presc <= presc + 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_o <= '0;
                    led_o   <= '0;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_arbiter.sv
// Self-checking bench for led_arbiter: directed vector tables, corner-case
// sequences and randomized traffic against a slot-level reference model.
module tb_led_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int TICK_DIV    = 4;
    localparam int SLICE_TICKS = 2;
    localparam int PWM_W       = 4;
    localparam int SLICE       = TICK_DIV * SLICE_TICKS;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [NUM_REQ-1:0]       req_i = '0;
    logic [3*NUM_REQ-1:0]     pattern_i = '0;
    logic [PWM_W*NUM_REQ-1:0] duty_i = '0;
    logic [NUM_REQ-1:0]       grant_o;
    logic [2:0]               led_o;
    logic                     busy_o;

    always #5 clk = ~clk;

    led_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .TICK_DIV    (TICK_DIV),
        .SLICE_TICKS (SLICE_TICKS),
        .PWM_W       (PWM_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_i),
        .pattern_i (pattern_i),
        .duty_i    (duty_i),
        .grant_o   (grant_o),
        .led_o     (led_o),
        .busy_o    (busy_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: who holds the pins (-1 = nobody), cycles elapsed
    // in the slice, last winner and the PWM phase since reset.
    int               m_gnt, m_ptr, m_el, m_ph, m_last_ph;
    logic [NUM_REQ-1:0] m_grant;
    logic [2:0]       m_led;

    task automatic model_reset();
        m_gnt = -1; m_ptr = NUM_REQ - 1; m_el = 0; m_ph = 0; m_last_ph = 0;
        m_grant = '0; m_led = '0;
    endtask

    function automatic logic [2:0] lit(input int k);
        logic [2:0] p;
        p = pattern_i[3*k +: 3];
`ifdef LED_ARB_PWM_EN
        if (m_ph >= int'(duty_i[PWM_W*k +: PWM_W])) p = 3'b000;
`endif
        return p;
    endfunction

    task automatic model_step();
        int w;
        w = -1;
        if (m_gnt < 0) begin
            if (req_i != '0) begin
                for (int i = 1; i <= NUM_REQ; i++)
                    if (w < 0 && req_i[(m_ptr + i) % NUM_REQ]) w = (m_ptr + i) % NUM_REQ;
                m_gnt = w; m_ptr = w; m_el = 0;
                m_led = lit(w);
            end else begin
                m_led = '0;
            end
        end else begin
            m_el++;
            if (!req_i[m_gnt] || m_el == SLICE) begin
                m_gnt = -1;
                m_led = '0;
            end else begin
                m_led = lit(m_gnt);
            end
        end
        m_last_ph = m_ph;
        m_ph      = (m_ph + 1) % (1 << PWM_W);
        m_grant   = (m_gnt < 0) ? '0 : (NUM_REQ'(1) << m_gnt);
    endtask

    // Every clock edge after reset release goes through here so the model
    // phase stays aligned with the hardware.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cmp_model(input string tag);
        check({tag, " grant"}, 32'(grant_o), 32'(m_grant));
        check({tag, " led"},   32'(led_o),   32'(m_led));
        check({tag, " busy"},  32'(busy_o),  32'(|m_grant));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        rst_before;
        logic [3:0]  req;
        logic [11:0] pat;
        logic [15:0] duty;
        logic [3:0]  exp_grant;
        logic [2:0]  exp_led;
    } vec_t;

    vec_t tbl[$];

    initial begin
        vec_t v;
        int   order[4];
        logic [2:0] rr_pat[4];
        logic [2:0] gate;
        int   cnt;

        // single requester: one 8-cycle slice, a SWITCH cycle, re-grant
        for (int c = 0; c < 11; c++) begin
            v.rst_before = (c == 0);
            v.req  = 4'b0001;
            v.pat  = 12'b000_000_000_101;
            v.duty = 16'hFFFF;
            v.exp_grant = (c == 8) ? 4'b0000 : 4'b0001;
            v.exp_led   = (c == 8) ? 3'b000  : 3'b101;
            tbl.push_back(v);
        end
        // round-robin over 1011: 0 -> 1 -> 3 -> 0
        order[0] = 0; order[1] = 1; order[2] = 3; order[3] = 0;
        rr_pat[0] = 3'b101; rr_pat[1] = 3'b110; rr_pat[2] = 3'b011; rr_pat[3] = 3'b100;
        for (int s = 0; s < 4; s++)
            for (int c = 0; c < 9; c++) begin
                v.rst_before = (s == 0 && c == 0);
                v.req  = 4'b1011;
                v.pat  = 12'b100_011_110_101;
                v.duty = 16'hFFFF;
                v.exp_grant = (c == 8) ? 4'b0000 : (4'b0001 << order[s]);
                v.exp_led   = (c == 8) ? 3'b000  : rr_pat[order[s]];
                tbl.push_back(v);
            end

        // reset state
        do_reset();
        check("reset grant", 32'(grant_o), 32'h0);
        check("reset led",   32'(led_o),   32'h0);
        check("reset busy",  32'(busy_o),  32'h0);

        foreach (tbl[i]) begin
            if (tbl[i].rst_before) do_reset();
            req_i = tbl[i].req; pattern_i = tbl[i].pat; duty_i = tbl[i].duty;
            tick();
            gate = 3'b111;
`ifdef LED_ARB_PWM_EN
            if (m_last_ph >= 15) gate = 3'b000;
`endif
            check($sformatf("tbl[%0d] grant", i), 32'(grant_o), 32'(tbl[i].exp_grant));
            check($sformatf("tbl[%0d] led", i),   32'(led_o),   32'(tbl[i].exp_led & gate));
            check($sformatf("tbl[%0d] busy", i),  32'(busy_o),  32'(|tbl[i].exp_grant));
        end

        // asynchronous reset in the middle of a slice
        do_reset();
        req_i = 4'b0001; pattern_i = 12'h007; duty_i = 16'hFFFF;
        tick(); tick(); tick();
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("midreset grant", 32'(grant_o), 32'h0);
        check("midreset led",   32'(led_o),   32'h0);
        check("midreset busy",  32'(busy_o),  32'h0);
        req_i = '0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("post-reset idle grant", 32'(grant_o), 32'h0);
        end

        // early release: requester 2 drops, pending requester 0 follows
        do_reset();
        req_i = 4'b0100; pattern_i = 12'b000_111_000_001; duty_i = 16'hFFFF;
        tick(); check("early first grant", 32'(grant_o), 32'h4); cmp_model("early");
        tick(); cmp_model("early");
        req_i = 4'b0101;
        tick(); cmp_model("early");
        tick(); cmp_model("early");
        req_i = 4'b0001;
        tick(); check("early switch grant", 32'(grant_o), 32'h0);
        check("early switch led", 32'(led_o), 32'h0);
        tick(); check("early next grant", 32'(grant_o), 32'h1); cmp_model("early");

        // late request waits for the slice end
        do_reset();
        req_i = 4'b0001; pattern_i = 12'b000_010_000_001; duty_i = 16'hFFFF;
        for (int c = 0; c < 10; c++) begin
            if (c == 3) req_i = 4'b0101;
            tick();
            check($sformatf("late c%0d grant", c), 32'(grant_o),
                  (c < 8) ? 32'h1 : (c == 8) ? 32'h0 : 32'h4);
            cmp_model("late");
        end

        // PWM brightness: duty 4 then duty 0 on pattern 111
        do_reset();
        req_i = 4'b0001; pattern_i = 12'h007; duty_i = 16'h0004;
        cnt = 0;
        for (int c = 0; c < 16; c++) begin
            tick(); cmp_model("pwm4");
            if (led_o == 3'b111) cnt++;
        end
`ifdef LED_ARB_PWM_EN
        check("pwm duty4 lit count", 32'(cnt), 32'd4);
`else
        check("pwm-off lit count", 32'(cnt), 32'd15);
`endif
        duty_i = 16'h0000;
        cnt = 0;
        for (int c = 0; c < 16; c++) begin
            tick(); cmp_model("pwm0");
            if (led_o != 3'b000) cnt++;
        end
`ifdef LED_ARB_PWM_EN
        check("pwm duty0 lit count", 32'(cnt), 32'd0);
`endif

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 5) == 0) req_i = NUM_REQ'($urandom);
            pattern_i = 12'($urandom);
            duty_i    = 16'($urandom);
            tick();
            cmp_model($sformatf("rand c%0d", c));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
